// File: rtl/alu_pipe_core.sv
// Two-stage RV32I ALU-class core: combinational decode/operand read with
// single-level EX bypass, registered EX stage, writeback and retire report.
module alu_pipe_core #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold,
  input  logic             inst_valid,
  input  logic [31:0]      inst,
  output logic             inst_ready,
  output logic             retire_valid,
  output logic [4:0]       retire_rd,
  output logic [XLEN-1:0]  retire_data,
  output logic             illegal,
  output logic [CNT_W-1:0] instret,
  input  logic [4:0]       dbg_addr,
  output logic [XLEN-1:0]  dbg_data
);

  localparam int SH_W  = $clog2(XLEN);
  localparam int IDX_W = $clog2(NREGS);
  localparam logic [5:0] NREGS_L = 6'(NREGS);

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
    OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND
  } alu_op_e;

  function automatic logic idx_ok(input logic [4:0] idx);
    return {1'b0, idx} < NREGS_L;
  endfunction

  function automatic alu_op_e op_of(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? OP_SUB : OP_ADD;
      3'b001:  return OP_SLL;
      3'b010:  return OP_SLT;
      3'b011:  return OP_SLTU;
      3'b100:  return OP_XOR;
      3'b101:  return alt ? OP_SRA : OP_SRL;
      3'b110:  return OP_OR;
      default: return OP_AND;
    endcase
  endfunction

  logic [XLEN-1:0] rf [NREGS];

  logic            ex_valid_reg;
  logic            ex_legal_reg;
  alu_op_e         ex_op_reg;
  logic [XLEN-1:0] ex_a_reg;
  logic [XLEN-1:0] ex_b_reg;
  logic [4:0]      ex_rd_reg;
  logic [XLEN-1:0] ex_result;

  logic             retire_valid_reg;
  logic [4:0]       retire_rd_reg;
  logic [XLEN-1:0]  retire_data_reg;
  logic             illegal_reg;
  logic [CNT_W-1:0] instret_reg;

  logic accept;
  logic wr_en;

  assign inst_ready = !hold && reset;
  assign accept     = inst_valid && inst_ready;
  assign wr_en      = ex_valid_reg && ex_legal_reg && (ex_rd_reg != 5'd0);

  // Field extraction
  logic [6:0] opcode;
  logic [4:0] rd;
  logic [2:0] funct3;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [6:0] funct7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;
  logic shamt_hi_zero;
  logic shamt_hi_sra;

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign funct3 = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign funct7 = inst[31:25];
  assign imm_i  = XLEN'($signed(inst[31:20]));
  assign imm_u  = XLEN'($signed({inst[31:12], 12'b0}));

  // On 64-bit datapaths bit 25 belongs to the shift amount.
  assign shamt_hi_zero = (XLEN == 64) ? (inst[31:26] == 6'b000000) : (inst[31:25] == 7'b0000000);
  assign shamt_hi_sra  = (XLEN == 64) ? (inst[31:26] == 6'b010000) : (inst[31:25] == 7'b0100000);

  // Operand read: x0 and out-of-range indices read 0; EX result bypasses the file.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      localparam int LSB = (gi == 0) ? 15 : 20;
      logic [4:0]      idx;
      logic [XLEN-1:0] val;
      assign idx = inst[LSB +: 5];
      always_comb begin
        if (idx == 5'd0 || !idx_ok(idx))
          val = '0;
        else if (ex_valid_reg && ex_legal_reg && ex_rd_reg == idx)
          val = ex_result;
        else
          val = rf[idx[IDX_W-1:0]];
      end
    end
  endgenerate

  logic            dec_legal;
  alu_op_e         dec_op;
  logic [XLEN-1:0] dec_a;
  logic [XLEN-1:0] dec_b;

  always_comb begin
    dec_legal = 1'b0;
    dec_op    = OP_ADD;
    dec_a     = g_src[0].val;
    dec_b     = g_src[1].val;
    case (opcode)
      7'b0110011: begin
        dec_op    = op_of(funct3, funct7[5]);
        dec_legal = idx_ok(rd) && idx_ok(rs1) && idx_ok(rs2) &&
                    ((funct7 == 7'b0000000) ||
                     (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)));
      end
      7'b0010011: begin
        dec_b     = imm_i;
        dec_op    = op_of(funct3, (funct3 == 3'b101) && inst[30]);
        dec_legal = idx_ok(rd) && idx_ok(rs1);
        if (funct3 == 3'b001)
          dec_legal = dec_legal && shamt_hi_zero;
        else if (funct3 == 3'b101)
          dec_legal = dec_legal && (shamt_hi_zero || shamt_hi_sra);
      end
      7'b0110111: begin
        dec_a     = '0;
        dec_b     = imm_u;
        dec_legal = idx_ok(rd);
      end
      default: ;
    endcase
  end

  logic [SH_W-1:0] ex_sh;
  assign ex_sh = ex_b_reg[SH_W-1:0];

  always_comb begin
    ex_result = '0;
    case (ex_op_reg)
      OP_ADD:  ex_result = ex_a_reg + ex_b_reg;
      OP_SUB:  ex_result = ex_a_reg - ex_b_reg;
      OP_SLL:  ex_result = ex_a_reg << ex_sh;
      OP_SLT:  ex_result = XLEN'($signed(ex_a_reg) < $signed(ex_b_reg));
      OP_SLTU: ex_result = XLEN'(ex_a_reg < ex_b_reg);
      OP_XOR:  ex_result = ex_a_reg ^ ex_b_reg;
      OP_SRL:  ex_result = ex_a_reg >> ex_sh;
      OP_SRA:  ex_result = $signed(ex_a_reg) >>> ex_sh;
      OP_OR:   ex_result = ex_a_reg | ex_b_reg;
      OP_AND:  ex_result = ex_a_reg & ex_b_reg;
      default: ex_result = '0;
    endcase
  end

  // EX payload needs no reset: ex_valid_reg qualifies every use of it.
  always_ff @(posedge clk) begin
    if (accept) begin
      ex_legal_reg <= dec_legal;
      ex_op_reg    <= dec_op;
      ex_a_reg     <= dec_a;
      ex_b_reg     <= dec_b;
      ex_rd_reg    <= rd;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_valid_reg     <= 1'b0;
      retire_valid_reg <= 1'b0;
      retire_rd_reg    <= '0;
      retire_data_reg  <= '0;
      illegal_reg      <= 1'b0;
      instret_reg      <= '0;
    end else begin
      ex_valid_reg     <= accept;
      retire_valid_reg <= ex_valid_reg && ex_legal_reg;
      illegal_reg      <= ex_valid_reg && !ex_legal_reg;
      if (ex_valid_reg && ex_legal_reg) begin
        retire_rd_reg   <= ex_rd_reg;
        retire_data_reg <= ex_result;
        instret_reg     <= instret_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++)
        rf[i] <= '0;
    end else if (wr_en) begin
      rf[ex_rd_reg[IDX_W-1:0]] <= ex_result;
    end
  end

  assign dbg_data = (dbg_addr != 5'd0 && idx_ok(dbg_addr)) ? rf[dbg_addr[IDX_W-1:0]] : '0;

  assign retire_valid = retire_valid_reg;
  assign retire_rd    = retire_rd_reg;
  assign retire_data  = retire_data_reg;
  assign illegal      = illegal_reg;
  assign instret      = instret_reg;

endmodule

// File: tb/tb_alu_pipe_core.sv
// Scoreboard bench for alu_pipe_core: directed scenarios plus random
// instruction streams checked against an instruction-level reference model.
module tb_alu_pipe_core;
  localparam int XLEN  = 32;
  localparam int NREGS = 16;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             hold;
  logic             inst_valid;
  logic [31:0]      inst;
  logic             inst_ready;
  logic             retire_valid;
  logic [4:0]       retire_rd;
  logic [XLEN-1:0]  retire_data;
  logic             illegal;
  logic [CNT_W-1:0] instret;
  logic [4:0]       dbg_addr;
  logic [XLEN-1:0]  dbg_data;

  alu_pipe_core #(.XLEN(XLEN), .NREGS(NREGS), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .hold(hold), .inst_valid(inst_valid), .inst(inst),
    .inst_ready(inst_ready), .retire_valid(retire_valid), .retire_rd(retire_rd),
    .retire_data(retire_data), .illegal(illegal), .instret(instret),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ill;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [7:0]  cnt;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mrf [NREGS];
  logic [7:0]  mcnt;
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_lui(input logic [19:0] imm, input logic [4:0] rd);
    return {imm, rd, 7'b0110111};
  endfunction

  function automatic logic [31:0] rd_model(input logic [4:0] r);
    if (r == 0 || r >= NREGS) return 32'd0;
    return mrf[r];
  endfunction

  // Architectural effect of one instruction, applied in program order.
  task automatic model_issue(input logic [31:0] x);
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic [6:0] f7, opc;
    logic [31:0] a, b, res;
    logic legal, alt, alu;
    exp_t e;
    opc = x[6:0]; rd = x[11:7]; f3 = x[14:12]; rs1 = x[19:15]; rs2 = x[24:20]; f7 = x[31:25];
    a = rd_model(rs1); b = 0; res = 0; legal = 0; alt = 0; alu = 0;
    if (opc == 7'b0110011) begin
      b = rd_model(rs2); alu = 1; alt = f7[5];
      legal = rd < NREGS && rs1 < NREGS && rs2 < NREGS &&
              (f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)));
    end else if (opc == 7'b0010011) begin
      b = {{20{x[31]}}, x[31:20]}; alu = 1; alt = (f3 == 5) && x[30];
      legal = rd < NREGS && rs1 < NREGS;
      if (f3 == 1) legal = legal && f7 == 0;
      if (f3 == 5) legal = legal && (f7 == 0 || f7 == 7'h20);
    end else if (opc == 7'b0110111) begin
      legal = rd < NREGS; res = {x[31:12], 12'b0};
    end
    if (alu) begin
      case (f3)
        0: res = alt ? a - b : a + b;
        1: res = a << b[4:0];
        2: res = ($signed(a) < $signed(b)) ? 1 : 0;
        3: res = (a < b) ? 1 : 0;
        4: res = a ^ b;
        5: res = alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
        6: res = a | b;
        default: res = a & b;
      endcase
    end
    if (legal) begin
      if (rd != 0) mrf[rd] = res;
      mcnt = mcnt + 1;
    end
    e.ill = !legal; e.rd = rd; e.data = res; e.cnt = mcnt;
    q.push_back(e);
  endtask

  task automatic model_clear();
    for (int i = 0; i < NREGS; i++) mrf[i] = 0;
    mcnt = 0;
  endtask

  // Transfer one instruction (hold=0, reset=1) and record its expected retirement.
  task automatic issue(input logic [31:0] x);
    inst = x; inst_valid = 1;
    @(posedge clk);
    model_issue(x);
    #1 inst_valid = 0;
  endtask

  task automatic idle(input int n);
    inst_valid = 0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_dbg(input string name, input logic [4:0] a, input logic [31:0] req);
    dbg_addr = a; #1;
    check(name, dbg_data, req);
  endtask

  function automatic logic [4:0] rreg();
    if ($urandom_range(0, 99) < 5) return 5'($urandom_range(16, 31));
    return 5'($urandom_range(0, NREGS - 1));
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [2:0] f3;
    logic [6:0] f7;
    int k;
    int imm_f3 [6] = '{0, 2, 3, 4, 6, 7};
    k = $urandom_range(0, 9);
    f3 = 3'($urandom_range(0, 7));
    case (k)
      0, 1, 2: begin
        f7 = ((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        return enc_r(f7, rreg(), rreg(), f3, rreg());
      end
      3, 4, 5: return enc_i(12'($urandom), rreg(), 3'(imm_f3[$urandom_range(0, 5)]), rreg());
      6: begin
        f3 = $urandom_range(0, 1) == 1 ? 3'd5 : 3'd1;
        f7 = (f3 == 5 && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        return enc_i({f7, 5'($urandom)}, rreg(), f3, rreg());
      end
      7: return enc_lui(20'($urandom), rreg());
      8: begin
        if ($urandom_range(0, 1) == 1)
          return enc_r(7'($urandom), rreg(), rreg(), f3, rreg());
        f3 = $urandom_range(0, 1) == 1 ? 3'd5 : 3'd1;
        return enc_i({7'($urandom), 5'($urandom)}, rreg(), f3, rreg());
      end
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every retire/illegal pulse is matched against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (retire_valid || illegal) begin
      if (q.size() == 0) begin
        check("unexpected_pulse", {retire_valid, illegal}, 0);
      end else begin
        e = q.pop_front();
        check("illegal_flag", illegal, e.ill);
        check("retire_valid", retire_valid, !e.ill);
        if (!e.ill) begin
          check("retire_rd", retire_rd, e.rd);
          check("retire_data", retire_data, e.data);
        end
        check("instret", instret, e.cnt);
        $display("[TB] retire ill=%0d rd=%0d data=%08h instret=%0d", illegal, retire_rd, retire_data, instret);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 0; hold = 0; inst_valid = 0; inst = 0; dbg_addr = 0;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready", inst_ready, 0);
    check("reset_instret", instret, 0);
    check("reset_retire", retire_valid, 0);
    @(posedge clk); #1 reset = 1;

    // Back-to-back ADDIs
    issue(enc_i(12'd5, 0, 0, 1));
    issue(enc_i(12'hFFD, 0, 0, 2));
    idle(2);
    check("t1_instret", instret, 2);
    check_dbg("t1_x1", 1, 32'd5);
    check_dbg("t1_x2", 2, 32'hFFFF_FFFD);

    // Forwarding from EX
    issue(enc_i(12'd7, 0, 0, 1));
    issue(enc_r(7'h00, 1, 1, 0, 3));
    idle(2);
    check_dbg("t2_x3", 3, 32'd14);

    // x0 destination / source
    issue(enc_i(12'd9, 0, 0, 0));
    issue(enc_r(7'h00, 0, 0, 0, 4));
    idle(2);
    check_dbg("t3_x4", 4, 32'd0);
    check_dbg("t3_x0", 0, 32'd0);
    check("t3_instret", instret, 6);

    // Shifts and unsigned compare
    issue(enc_lui(20'h80000, 1));
    issue(enc_i(12'd1, 0, 0, 2));
    issue(enc_i({7'h20, 5'd4}, 1, 5, 5));
    issue(enc_i({7'h00, 5'd4}, 1, 5, 7));
    issue(enc_r(7'h00, 2, 1, 3'd3, 6));
    idle(2);
    check_dbg("t4_srai", 5, 32'hF800_0000);
    check_dbg("t4_srli", 7, 32'h0800_0000);
    check_dbg("t4_sltu", 6, 32'd0);
    check("t4_instret", instret, 11);

    // Illegal instructions
    issue({12'd1, 5'd0, 3'd0, 5'd8, 7'b0000011});
    issue(enc_r(7'h01, 1, 1, 0, 8));
    issue(enc_r(7'h00, 1, 1, 0, 20));
    idle(2);
    check("t5_instret", instret, 11);
    check_dbg("t5_x8", 8, 32'd0);
    check_dbg("t5_x20", 20, 32'd0);

    // hold blocks acceptance while EX drains
    issue(enc_i(12'd33, 0, 0, 9));
    hold = 1; inst_valid = 1; inst = enc_i(12'd44, 0, 0, 10);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_ready", inst_ready, 0);
      @(posedge clk); #1;
    end
    check_dbg("hold_x10_untouched", 10, 32'd0);
    hold = 0;
    issue(enc_i(12'd44, 0, 0, 10));
    idle(2);
    check_dbg("hold_x9", 9, 32'd33);
    check_dbg("hold_x10", 10, 32'd44);

    // Reset with an instruction in EX
    issue(enc_i(12'd1, 0, 0, 11));
    issue(enc_i(12'd77, 0, 0, 12));
    reset = 0;
    void'(q.pop_back());
    model_clear();
    @(posedge clk);
    @(negedge clk);
    check("rst_retire", retire_valid, 0);
    check("rst_instret", instret, 0);
    check("rst_ready", inst_ready, 0);
    for (int a = 0; a < 32; a++) check_dbg("rst_dbg", 5'(a), 32'd0);
    @(posedge clk); #1 reset = 1;

    // Random stream with periodic register-file comparison
    for (int n = 0; n < 700; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 8) begin
        hold = 1; inst_valid = 1; inst = rand_inst();
        @(negedge clk);
        check("rand_hold_ready", inst_ready, 0);
        @(posedge clk); #1;
        hold = 0; inst_valid = 0;
      end else if (r < 14) begin
        idle(1);
      end else begin
        issue(rand_inst());
      end
      if (n % 50 == 49) begin
        idle(2);
        for (int a = 0; a < NREGS; a++) check_dbg("rand_rf", 5'(a), rd_model(5'(a)));
        check("rand_instret", instret, mcnt);
      end
    end

    idle(3);
    check("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
